// File: rtl/uart_loader.sv
// uart_loader: UART-driven program loader acting as a rib bus master.
// A host sends framed packets on rx_pin: 0xA5 | addr (4B, LSB first) | len (2B, words)
// | len*4 data bytes (LSB first) | csum (XOR of data bytes). Each assembled 32-bit
// word is written via a single-cycle req_o/mem_we_o strobe. After the checksum, one
// status byte is returned on tx_pin: 0x5A (match) or 0xEE (mismatch).
// Ports:
//   clk, rst (async, active low), debug_en_i (loader enable)
//   rx_pin / tx_pin      : 8N1 UART lines, idle high
//   req_o, mem_we_o      : rib write strobe, high for exactly one cycle per word
//   mem_addr_o/wdata_o   : rib address and data, valid while req_o is high
//   busy_o               : packet in progress (header seen, response not yet sent)
//   err_o                : sticky error flag, cleared by the next valid header
module uart_loader #(
    parameter int CLK_FREQ = 50000000,
    parameter int BAUD     = 115200,
    parameter int TIMEOUT  = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        debug_en_i,
    input  logic        rx_pin,
    output logic        tx_pin,
    output logic        req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic        busy_o,
    output logic        err_o
);
    localparam int BIT_CNT = CLK_FREQ / BAUD;
    localparam int CW      = $clog2(BIT_CNT + 1);
    localparam int TW      = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] BIT_MAX  = CW'(BIT_CNT - 1);
    localparam logic [CW-1:0] HALF_MAX = CW'(BIT_CNT / 2 - 1);
    localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, ADDR, LEN, DATA, WRITE, CSUM, RESP} state_t;
    state_t state, state_n;

    // ---------------- receiver ----------------
    logic          rx_s1, rx_s2, rx_prev, rx_on, rx_done, rx_ferr, rx_tick;
    logic [CW-1:0] rx_cnt;
    logic [3:0]    rx_bit;   // 0 = start check, 1..8 = data, 9 = stop
    logic [7:0]    rx_sh;

    assign rx_tick = (rx_bit == 4'd0) ? (rx_cnt == HALF_MAX) : (rx_cnt == BIT_MAX);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_s1 <= 1'b1; rx_s2 <= 1'b1; rx_prev <= 1'b1;
            rx_on <= 1'b0; rx_cnt <= '0; rx_bit <= '0; rx_sh <= '0;
            rx_done <= 1'b0; rx_ferr <= 1'b0;
        end else begin
            rx_s1   <= rx_pin;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
            rx_done <= 1'b0;
            rx_ferr <= 1'b0;
            if (!debug_en_i) begin
                rx_on <= 1'b0;
            end else if (!rx_on) begin
                if (rx_prev && !rx_s2) begin
                    rx_on  <= 1'b1;
                    rx_cnt <= '0;
                    rx_bit <= '0;
                end
            end else if (!rx_tick) begin
                rx_cnt <= rx_cnt + 1'b1;
            end else begin
                rx_cnt <= '0;
                if (rx_bit == 4'd0) begin
                    // start bit high again at mid-bit: treat the edge as a glitch
                    if (rx_s2) rx_on <= 1'b0;
                    else       rx_bit <= 4'd1;
                end else if (rx_bit <= 4'd8) begin
                    rx_sh  <= {rx_s2, rx_sh[7:1]};
                    rx_bit <= rx_bit + 4'd1;
                end else begin
                    rx_on   <= 1'b0;
                    rx_done <= rx_s2;
                    rx_ferr <= ~rx_s2;
                end
            end
        end
    end

    // ---------------- packet engine ----------------
    logic          byte_ok, frame_bad, in_pkt, timeout, tx_done;
    logic [31:0]   addr, wdata;
    logic [15:0]   wcount;
    logic [1:0]    cnt;
    logic [7:0]    csum, tx_sh;
    logic          err, tx_reg;
    logic [TW-1:0] to_cnt;
    logic [CW-1:0] tx_cnt;
    logic [3:0]    tx_bit;   // bits fully sent: start, 8 data, stop

    assign byte_ok   = rx_done & debug_en_i;
    assign frame_bad = rx_ferr & debug_en_i;
    assign in_pkt    = (state != IDLE) && (state != RESP);
    assign timeout   = debug_en_i && in_pkt && (to_cnt == TO_MAX) && !rx_done;
    assign tx_done   = (state == RESP) && (tx_cnt == BIT_MAX) && (tx_bit == 4'd9);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_n;
    end

    always_comb begin
        state_n = state;
        if (!debug_en_i) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE:  if (byte_ok && rx_sh == 8'hA5) state_n = ADDR;
                ADDR:  if (byte_ok && cnt == 2'd3) state_n = LEN;
                LEN:   if (byte_ok && cnt == 2'd1)
                           state_n = ({rx_sh, wcount[15:8]} == 16'd0) ? CSUM : DATA;
                DATA:  if (byte_ok && cnt == 2'd3) state_n = WRITE;
                WRITE: state_n = (wcount == 16'd1) ? CSUM : DATA;
                CSUM:  if (byte_ok) state_n = RESP;
                RESP:  if (tx_done) state_n = IDLE;
                default: state_n = IDLE;
            endcase
            if (in_pkt && (frame_bad || timeout)) state_n = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr <= '0; wdata <= '0; wcount <= '0; cnt <= '0; csum <= '0;
            err <= 1'b0; to_cnt <= '0;
            tx_reg <= 1'b1; tx_sh <= '0; tx_cnt <= '0; tx_bit <= '0;
        end else begin
            to_cnt <= (!in_pkt || byte_ok) ? '0 : to_cnt + 1'b1;
            if ((frame_bad && state != RESP) || timeout) err <= 1'b1;
            if (!debug_en_i) begin
                tx_reg <= 1'b1;
            end else begin
                case (state)
                    IDLE: if (byte_ok && rx_sh == 8'hA5) begin
                        err <= 1'b0; cnt <= '0; csum <= '0;
                    end
                    ADDR: if (byte_ok) begin
                        addr <= {rx_sh, addr[31:8]};
                        cnt  <= cnt + 2'd1;
                    end
                    LEN: if (byte_ok) begin
                        wcount <= {rx_sh, wcount[15:8]};
                        cnt    <= (cnt == 2'd1) ? 2'd0 : cnt + 2'd1;
                    end
                    DATA: if (byte_ok) begin
                        wdata <= {rx_sh, wdata[31:8]};
                        csum  <= csum ^ rx_sh;
                        cnt   <= cnt + 2'd1;
                    end
                    WRITE: begin
                        addr   <= addr + 32'd4;
                        wcount <= wcount - 16'd1;
                    end
                    CSUM: if (byte_ok) begin
                        tx_reg <= 1'b0;   // start bit goes out immediately
                        tx_sh  <= (rx_sh == csum) ? 8'h5A : 8'hEE;
                        tx_cnt <= '0;
                        tx_bit <= '0;
                        if (rx_sh != csum) err <= 1'b1;
                    end
                    RESP: begin
                        if (tx_cnt != BIT_MAX) begin
                            tx_cnt <= tx_cnt + 1'b1;
                        end else begin
                            tx_cnt <= '0;
                            if (tx_bit == 4'd9) begin
                                tx_reg <= 1'b1;
                            end else begin
                                tx_reg <= (tx_bit == 4'd8) ? 1'b1 : tx_sh[0];
                                tx_sh  <= {1'b0, tx_sh[7:1]};
                                tx_bit <= tx_bit + 4'd1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign req_o       = (state == WRITE) && debug_en_i;
    assign mem_we_o    = req_o;
    assign mem_addr_o  = addr;
    assign mem_wdata_o = wdata;
    assign busy_o      = (state != IDLE);
    assign err_o       = err;
    assign tx_pin      = tx_reg;
endmodule

// File: tb/tb_uart_loader.sv
// Directed bench for uart_loader: drives 8N1 packets on rx_pin, logs rib writes and
// decodes the tx_pin status byte, and checks them against hand-computed values.
module tb_uart_loader;
    localparam int BIT = 8;     // CLK_FREQ/BAUD = 80/10
    localparam int TO  = 300;

    logic        clk = 1'b0, rst = 1'b0, debug_en_i = 1'b1, rx_pin = 1'b1;
    logic        tx_pin, req_o, mem_we_o, busy_o, err_o;
    logic [31:0] mem_addr_o, mem_wdata_o;

    uart_loader #(.CLK_FREQ(80), .BAUD(10), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .debug_en_i(debug_en_i), .rx_pin(rx_pin),
        .tx_pin(tx_pin), .req_o(req_o), .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .busy_o(busy_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;

    // write log: one entry per cycle with req_o high
    logic [31:0] wr_addr [0:31];
    logic [31:0] wr_data [0:31];
    logic        wr_we   [0:31];
    int          wr_n = 0;
    always @(negedge clk) begin
        if (req_o && wr_n < 32) begin
            wr_addr[wr_n] <= mem_addr_o;
            wr_data[wr_n] <= mem_wdata_o;
            wr_we[wr_n]   <= mem_we_o;
            wr_n          <= wr_n + 1;
        end
    end

    // tx decoder
    logic [7:0] tx_byte [0:15];
    int         tx_n = 0;
    logic [7:0] txm_b;
    initial forever begin
        @(negedge clk);
        if (rst && tx_pin === 1'b0) begin
            repeat (BIT/2) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
                repeat (BIT) @(negedge clk);
                txm_b[i] = tx_pin;
            end
            repeat (BIT) @(negedge clk);
            if (tx_n < 16) begin
                tx_byte[tx_n] = (tx_pin === 1'b1) ? txm_b : 8'hxx;
                tx_n = tx_n + 1;
            end
        end
    end

    logic [31:0] words [0:3];

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
        rx_pin = 1'b0;
        tick(BIT);
        for (int i = 0; i < 8; i++) begin
            rx_pin = b[i];
            tick(BIT);
        end
        rx_pin = stop;
        tick(BIT);
        rx_pin = 1'b1;
        tick(2);
    endtask

    task automatic send_hdr_partial(input int ndata);
        send_byte(8'hA5);
        for (int k = 0; k < 4; k++) send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'h00);
        for (int k = 0; k < ndata; k++) send_byte(8'h77);
    endtask

    task automatic send_packet(input logic [31:0] a, input int n, input logic [7:0] flip);
        logic [7:0] cs, by;
        cs = 8'h00;
        send_byte(8'hA5);
        @(negedge clk);
        chk("busy_after_hdr", busy_o, 1);
        chk("err_clr_hdr", err_o, 0);
        tick(1);
        for (int k = 0; k < 4; k++) send_byte(a[8*k +: 8]);
        send_byte(n[7:0]);
        send_byte(n[15:8]);
        for (int w = 0; w < n; w++)
            for (int k = 0; k < 4; k++) begin
                by = words[w][8*k +: 8];
                cs = cs ^ by;
                send_byte(by);
            end
        send_byte(cs ^ flip);
    endtask

    task automatic wait_idle(input string tag);
        int k;
        k = 0;
        while (busy_o && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk(tag, busy_o, 0);
        tick(1);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int wb, tb0;
        // reset values
        tick(3);
        @(negedge clk);
        chk("rst_tx", tx_pin, 1);
        chk("rst_req", req_o, 0);
        chk("rst_we", mem_we_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_addr", mem_addr_o, 0);
        chk("rst_wdata", mem_wdata_o, 0);
        rst = 1'b1;
        tick(5);

        // single word at 0x0
        wb = wr_n; tb0 = tx_n;
        words[0] = 32'h11223344;
        send_packet(32'h0, 1, 8'h00);
        wait_idle("t1_idle");
        chk("t1_nwr", wr_n - wb, 1);
        chk("t1_addr", wr_addr[wb], 32'h0);
        chk("t1_data", wr_data[wb], 32'h11223344);
        chk("t1_we", wr_we[wb], 1);
        chk("t1_ntx", tx_n - tb0, 1);
        chk("t1_tx", tx_byte[tb0], 8'h5A);
        chk("t1_err", err_o, 0);

        // three words
        wb = wr_n; tb0 = tx_n;
        words[0] = 32'h01020304; words[1] = 32'hA0B0C0D0; words[2] = 32'hDEADBEEF;
        send_packet(32'h10000000, 3, 8'h00);
        wait_idle("t2_idle");
        chk("t2_nwr", wr_n - wb, 3);
        chk("t2_addr0", wr_addr[wb],   32'h10000000);
        chk("t2_addr1", wr_addr[wb+1], 32'h10000004);
        chk("t2_addr2", wr_addr[wb+2], 32'h10000008);
        chk("t2_data0", wr_data[wb],   32'h01020304);
        chk("t2_data1", wr_data[wb+1], 32'hA0B0C0D0);
        chk("t2_data2", wr_data[wb+2], 32'hDEADBEEF);
        chk("t2_tx", tx_byte[tb0], 8'h5A);

        // bad checksum (0x00 instead of 0x44)
        wb = wr_n; tb0 = tx_n;
        words[0] = 32'h11223344;
        send_packet(32'h0, 1, 8'h44);
        wait_idle("t3_idle");
        chk("t3_nwr", wr_n - wb, 1);
        chk("t3_data", wr_data[wb], 32'h11223344);
        chk("t3_tx", tx_byte[tb0], 8'hEE);
        chk("t3_err", err_o, 1);

        // address wrap
        wb = wr_n; tb0 = tx_n;
        words[0] = 32'hCAFEF00D; words[1] = 32'h0BADBEEF;
        send_packet(32'hFFFFFFFC, 2, 8'h00);
        wait_idle("t4_idle");
        chk("t4_nwr", wr_n - wb, 2);
        chk("t4_addr0", wr_addr[wb], 32'hFFFFFFFC);
        chk("t4_addr1", wr_addr[wb+1], 32'h00000000);
        chk("t4_data1", wr_data[wb+1], 32'h0BADBEEF);
        chk("t4_tx", tx_byte[tb0], 8'h5A);
        chk("t4_err", err_o, 0);

        // framing error mid-ADDR
        wb = wr_n; tb0 = tx_n;
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h12, 1'b0);
        @(negedge clk);
        chk("t5_err", err_o, 1);
        chk("t5_busy", busy_o, 0);
        tick(100);
        chk("t5_nwr", wr_n - wb, 0);
        chk("t5_ntx", tx_n - tb0, 0);
        words[0] = 32'h55AA00FF;
        send_packet(32'h20, 1, 8'h00);
        wait_idle("t5b_idle");
        chk("t5b_addr", wr_addr[wb], 32'h20);
        chk("t5b_tx", tx_byte[tb0], 8'h5A);

        // reset mid-DATA
        send_hdr_partial(2);
        rst = 1'b0;
        @(negedge clk);
        chk("t6_busy", busy_o, 0);
        chk("t6_req", req_o, 0);
        chk("t6_tx", tx_pin, 1);
        chk("t6_addr", mem_addr_o, 0);
        tick(2);
        rst = 1'b1;
        tick(3);
        wb = wr_n; tb0 = tx_n;
        words[0] = 32'h89ABCDEF;
        send_packet(32'h40, 1, 8'h00);
        wait_idle("t6b_idle");
        chk("t6b_nwr", wr_n - wb, 1);
        chk("t6b_data", wr_data[wb], 32'h89ABCDEF);
        chk("t6b_tx", tx_byte[tb0], 8'h5A);

        // enable dropped mid-DATA, rx ignored while disabled
        send_hdr_partial(2);
        debug_en_i = 1'b0;
        tick(1);
        @(negedge clk);
        chk("t7_busy", busy_o, 0);
        chk("t7_req", req_o, 0);
        send_byte(8'hA5);
        @(negedge clk);
        chk("t7_rx_ignored", busy_o, 0);
        debug_en_i = 1'b1;
        tick(3);

        // enable dropped during a 0xEE response: tx aborted, err held
        words[0] = 32'h11223344;
        send_packet(32'h0, 1, 8'h44);
        @(negedge clk);
        chk("t8_startbit", tx_pin, 0);
        debug_en_i = 1'b0;
        tick(1);
        @(negedge clk);
        chk("t8_tx_abort", tx_pin, 1);
        chk("t8_busy", busy_o, 0);
        chk("t8_err_held", err_o, 1);
        tick(100);
        debug_en_i = 1'b1;
        tick(3);

        // len = 0: straight to checksum, expected 0x00
        wb = wr_n; tb0 = tx_n;
        send_packet(32'h80, 0, 8'h00);
        wait_idle("t9_idle");
        chk("t9_nwr", wr_n - wb, 0);
        chk("t9_tx", tx_byte[tb0], 8'h5A);

        // timeout inside a packet
        wb = wr_n; tb0 = tx_n;
        send_byte(8'hA5);
        tick(TO + 50);
        @(negedge clk);
        chk("t10_err", err_o, 1);
        chk("t10_busy", busy_o, 0);
        chk("t10_ntx", tx_n - tb0, 0);
        chk("t10_nwr", wr_n - wb, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
